// File: rtl/laplace_pkg.sv
// rtl/laplace_pkg.sv - shared constants for the Laplace cross-window feeder and kernel
package laplace_pkg;

  localparam int LAPLACE_PIX_W = 8;
  localparam int LAPLACE_IMG_W = 640;
  localparam int LAPLACE_IMG_H = 480;

  // Window bus is packed {b,d,e,f,h}, b in the top field, h in the bottom one.
  localparam int WIN_FIELDS = 5;
  localparam int WIN_B      = 4;
  localparam int WIN_D      = 3;
  localparam int WIN_E      = 2;
  localparam int WIN_F      = 1;
  localparam int WIN_H      = 0;

endpackage

// File: rtl/laplace_cross_window_if.sv
// rtl/laplace_cross_window_if.sv - pixel-in and window-out handshake bundle
interface laplace_cross_window_if #(
  parameter int PIX_W = laplace_pkg::LAPLACE_PIX_W
) ();

  logic [PIX_W-1:0] pix_in;
  logic             pix_sof;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] b;
  logic [PIX_W-1:0] d;
  logic [PIX_W-1:0] e;
  logic [PIX_W-1:0] f;
  logic [PIX_W-1:0] h;
  logic             win_valid;
  logic             win_ready;
  logic             win_last;
  logic             sync_err;

  modport master (
    output pix_in, pix_sof, pix_valid, win_ready,
    input  pix_ready, b, d, e, f, h, win_valid, win_last, sync_err
  );

  modport slave (
    input  pix_in, pix_sof, pix_valid, win_ready,
    output pix_ready, b, d, e, f, h, win_valid, win_last, sync_err
  );

endinterface

// File: rtl/laplace_line_buffer.sv
// rtl/laplace_line_buffer.sv - one-row pixel delay line for the cross-window feeder
// Write is clocked; the read port returns the contents from before this cycle's write.
module laplace_line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/laplace_cross_window.sv
// rtl/laplace_cross_window.sv - raster pixel stream to 5-point cross windows for the Laplace kernel
// Two line buffers hold rows r-1 and r-2; one output register carries the window downstream.
module laplace_cross_window #(
  parameter int PIX_W = laplace_pkg::LAPLACE_PIX_W,
  parameter int IMG_W = laplace_pkg::LAPLACE_IMG_W,
  parameter int IMG_H = laplace_pkg::LAPLACE_IMG_H
) (
  input  logic                   clk,
  input  logic                   rst_n,
  laplace_cross_window_if.slave  io
);
  import laplace_pkg::*;

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int WIN_W = WIN_FIELDS * PIX_W;

  logic [CW-1:0]    col_q, col_d, col_eff;
  logic [RW-1:0]    row_q, row_d, row_eff;
  logic [PIX_W-1:0] t0_q, t0_d;
  logic [PIX_W-1:0] t1a_q, t1a_d;
  logic [PIX_W-1:0] t1b_q, t1b_d;
  logic [PIX_W-1:0] t2_q, t2_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             sync_err_q, sync_err_d;
  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic             accept, load_win, col_end, row_end;

  laplace_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (col_eff),
    .wdata_i (io.pix_in),
    .rdata_o (lb1_rd)
  );

  laplace_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk     (clk),
    .en_i    (accept),
    .addr_i  (col_eff),
    .wdata_i (lb1_rd),
    .rdata_o (lb2_rd)
  );

  always_comb begin
    accept   = io.pix_valid && io.pix_ready;
    // A start-of-frame pixel is (0,0) whatever the counters say.
    col_eff  = io.pix_sof ? '0 : col_q;
    row_eff  = io.pix_sof ? '0 : row_q;
    col_end  = (col_eff == CW'(IMG_W - 1));
    row_end  = (row_eff == RW'(IMG_H - 1));
    load_win = accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));

    col_d       = col_q;
    row_d       = row_q;
    t0_d        = t0_q;
    t1a_d       = t1a_q;
    t1b_d       = t1b_q;
    t2_d        = t2_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    sync_err_d  = 1'b0;

    if (accept) begin
      col_d      = col_end ? '0 : col_eff + 1'b1;
      row_d      = col_end ? (row_end ? '0 : row_eff + 1'b1) : row_eff;
      t0_d       = io.pix_in;
      t1a_d      = lb1_rd;
      t1b_d      = t1a_q;
      t2_d       = lb2_rd;
      sync_err_d = io.pix_sof && ((col_q != '0) || (row_q != '0));
    end

    // Accepting (r,c) completes the window centred on (r-1,c-1).
    if (load_win) begin
      win_d[WIN_B*PIX_W +: PIX_W] = t2_q;
      win_d[WIN_D*PIX_W +: PIX_W] = t1b_q;
      win_d[WIN_E*PIX_W +: PIX_W] = t1a_q;
      win_d[WIN_F*PIX_W +: PIX_W] = lb1_rd;
      win_d[WIN_H*PIX_W +: PIX_W] = t0_q;
      win_valid_d = 1'b1;
      win_last_d  = row_end && col_end;
    end else if (io.win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      t0_q        <= '0;
      t1a_q       <= '0;
      t1b_q       <= '0;
      t2_q        <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      t0_q        <= t0_d;
      t1a_q       <= t1a_d;
      t1b_q       <= t1b_d;
      t2_q        <= t2_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign io.pix_ready = !win_valid_q || io.win_ready;
  assign io.win_valid = win_valid_q;
  assign io.win_last  = win_last_q;
  assign io.sync_err  = sync_err_q;
  assign io.b         = win_q[WIN_B*PIX_W +: PIX_W];
  assign io.d         = win_q[WIN_D*PIX_W +: PIX_W];
  assign io.e         = win_q[WIN_E*PIX_W +: PIX_W];
  assign io.f         = win_q[WIN_F*PIX_W +: PIX_W];
  assign io.h         = win_q[WIN_H*PIX_W +: PIX_W];

endmodule

// File: tb/tb_laplace_cross_window.sv
// tb/tb_laplace_cross_window.sv - self-checking bench for laplace_cross_window
module tb_laplace_cross_window;

  localparam int PIX_W = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] f;
    logic [7:0] h;
    logic       last;
  } win_t;

  typedef struct {
    int   trig;
    win_t w;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  laplace_cross_window_if #(.PIX_W(PIX_W)) bus ();

  laplace_cross_window #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   err_cnt = 0;
  int   exp_err = 0;
  win_t got_q[$];
  win_t exp_q[$];
  int   win_cyc_q[$];
  int   acc_cyc_q[$];
  vec_t tbl[NWIN];
  int   m_row = 0;
  int   m_col = 0;
  logic [7:0] img[IMG_H][IMG_W];
  bit   rnd_done;

  always @(posedge clk) cyc++;

  task automatic chk_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input win_t act, input win_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got b=%0d d=%0d e=%0d f=%0d h=%0d last=%0d expected b=%0d d=%0d e=%0d f=%0d h=%0d last=%0d",
               name, act.b, act.d, act.e, act.f, act.h, act.last, exp.b, exp.d, exp.e, exp.f, exp.h, exp.last);
    end
  endtask

  function automatic win_t cur_win();
    win_t w;
    w.b = bus.b; w.d = bus.d; w.e = bus.e; w.f = bus.f; w.h = bus.h; w.last = bus.win_last;
    return w;
  endfunction

  function automatic vec_t mk(input int trig, input int b, input int d, input int e,
                              input int f, input int h, input bit last);
    vec_t v;
    v.trig = trig;
    v.w.b = 8'(b); v.w.d = 8'(d); v.w.e = 8'(e); v.w.f = 8'(f); v.w.h = 8'(h); v.w.last = last;
    return v;
  endfunction

  function automatic logic [7:0] pv(input int idx);
    return 8'(16 * (idx / IMG_W) + idx % IMG_W);
  endfunction

  // Reference: place each accepted pixel in a 2-D image, emit the cross around (r-1,c-1).
  task automatic model_accept(input logic [7:0] px, input logic sof);
    int r, c;
    win_t w;
    if (sof) begin
      if (m_row != 0 || m_col != 0) exp_err++;
      r = 0; c = 0;
    end else begin
      r = m_row; c = m_col;
    end
    img[r][c] = px;
    if (r >= 2 && c >= 2) begin
      w.b = img[r-2][c-1]; w.d = img[r-1][c-2]; w.e = img[r-1][c-1];
      w.f = img[r-1][c];   w.h = img[r][c-1];
      w.last = (r == IMG_H - 1) && (c == IMG_W - 1);
      exp_q.push_back(w);
    end
    c++;
    if (c == IMG_W) begin
      c = 0;
      r = (r == IMG_H - 1) ? 0 : r + 1;
    end
    m_row = r; m_col = c;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.win_valid && bus.win_ready) begin
        got_q.push_back(cur_win());
        win_cyc_q.push_back(cyc);
      end
      if (bus.sync_err) err_cnt++;
      if (bus.pix_valid && bus.pix_ready) begin
        acc_cyc_q.push_back(cyc);
        model_accept(bus.pix_in, bus.pix_sof);
      end
    end else begin
      m_row = 0;
      m_col = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete(); exp_q.delete(); win_cyc_q.delete(); acc_cyc_q.delete();
    err_cnt = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_in = '0; bus.win_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic push_pix(input logic [7:0] v, input logic sof, input int gap);
    bit ok = 1'b0;
    bus.pix_valid = 1'b0;
    repeat (gap) tick();
    bus.pix_in = v; bus.pix_sof = sof; bus.pix_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.pix_ready;
      tick();
    end
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: pixel %0d not accepted within 200 cycles", v);
    end
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < IMG_W * IMG_H; i++)
      push_pix(pv(i), i == 0, (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
  endtask

  task automatic check_stream(input string name, input int nfr);
    chk_i({name, ".count"}, got_q.size(), NWIN * nfr);
    for (int i = 0; i < got_q.size() && i < NWIN * nfr; i++)
      chk_w($sformatf("%s.win%0d", name, i), got_q[i], tbl[i % NWIN].w);
  endtask

  initial begin
    tbl[0] = mk(12,  1, 16, 17, 18, 33, 1'b0);
    tbl[1] = mk(13,  2, 17, 18, 19, 34, 1'b0);
    tbl[2] = mk(14,  3, 18, 19, 20, 35, 1'b0);
    tbl[3] = mk(17, 17, 32, 33, 34, 49, 1'b0);
    tbl[4] = mk(18, 18, 33, 34, 35, 50, 1'b0);
    tbl[5] = mk(19, 19, 34, 35, 36, 51, 1'b1);

    do_reset();
    @(negedge clk);
    chk_i("reset.win_valid", int'(bus.win_valid), 0);
    chk_i("reset.win_last", int'(bus.win_last), 0);
    chk_i("reset.sync_err", int'(bus.sync_err), 0);
    chk_i("reset.pix_ready", int'(bus.pix_ready), 1);
    chk_w("reset.window", cur_win(), '0);
    tick();

    // Test 1: one clean frame, latency of every window
    send_frame(0);
    repeat (3) tick();
    check_stream("t1", 1);
    chk_i("t1.sync_err", err_cnt, 0);
    chk_i("t1.accepts", acc_cyc_q.size(), IMG_W * IMG_H);
    if (acc_cyc_q.size() == IMG_W * IMG_H && win_cyc_q.size() == NWIN)
      for (int i = 0; i < NWIN; i++)
        chk_i($sformatf("t1.latency%0d", i), win_cyc_q[i], acc_cyc_q[tbl[i].trig] + 1);

    // Test 2: input gaps plus a 3-cycle downstream stall on window 2
    do_reset();
    fork
      send_frame(2);
      begin
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
          if (bus.win_valid && got_q.size() == 1) begin
            bus.win_ready = 1'b0;
            repeat (3) begin
              @(negedge clk);
              chk_i("t2.stall_valid", int'(bus.win_valid), 1);
              chk_i("t2.stall_pix_ready", int'(bus.pix_ready), 0);
              chk_w("t2.stall_hold", cur_win(), tbl[1].w);
              tick();
            end
            bus.win_ready = 1'b1;
            done = 1'b1;
          end else begin
            tick();
          end
        end
        if (!done) begin
          n_cmp++; n_bad++;
          $display("FAIL t2.stall_timeout: window 2 never seen");
        end
      end
    join
    repeat (3) tick();
    check_stream("t2", 1);

    // Test 3: two frames back to back
    do_reset();
    send_frame(0);
    send_frame(0);
    repeat (3) tick();
    check_stream("t3", 2);
    chk_i("t3.sync_err", err_cnt, 0);

    // Test 4: sof on pixel 7 restarts the frame
    do_reset();
    for (int i = 0; i < 7; i++) push_pix(pv(i), i == 0, 0);
    send_frame(0);
    repeat (3) tick();
    check_stream("t4", 1);
    chk_i("t4.sync_err", err_cnt, 1);

    // Test 5: reset after pixel 13, then a full frame
    do_reset();
    for (int i = 0; i < 14; i++) push_pix(pv(i), i == 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_i("t5.win_valid", int'(bus.win_valid), 0);
    chk_i("t5.win_last", int'(bus.win_last), 0);
    chk_i("t5.sync_err", int'(bus.sync_err), 0);
    chk_w("t5.window", cur_win(), '0);
    tick();
    clear_q();
    send_frame(0);
    repeat (3) tick();
    check_stream("t5", 1);

    // Test 6: downstream blocked after the first window
    do_reset();
    bus.win_ready = 1'b0;
    for (int i = 0; i < 13; i++) push_pix(pv(i), i == 0, 0);
    bus.pix_in = pv(13); bus.pix_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_i("t6.win_valid", int'(bus.win_valid), 1);
      chk_i("t6.pix_ready", int'(bus.pix_ready), 0);
      chk_w("t6.hold", cur_win(), tbl[0].w);
      tick();
    end
    chk_i("t6.accepts", acc_cyc_q.size(), 13);
    chk_i("t6.consumed", got_q.size(), 0);
    bus.win_ready = 1'b1;
    for (int i = 13; i < IMG_W * IMG_H; i++) push_pix(pv(i), 1'b0, 0);
    repeat (3) tick();
    check_stream("t6", 1);

    // Random traffic against the image model
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++)
          push_pix(8'($urandom), $urandom_range(0, 29) == 0,
                   ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.win_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    bus.win_ready = 1'b1;
    repeat (4) tick();
    chk_i("rnd.count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk_w($sformatf("rnd.win%0d", i), got_q[i], exp_q[i]);
    chk_i("rnd.sync_err", err_cnt, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
